// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sequencer
//  Description : Command-driven initiator for an 8 x 16-bit register file.
//                Accepts LOAD / MOV / SWAP / CLEAR commands over a
//                valid/ready handshake and sequences them onto the register
//                file's single read port and single write port.
//  Ports       : clk, reset              - clock, async active-high reset
//                cmd_valid / cmd_ready   - command handshake (ready in IDLE)
//                cmd_op, cmd_rd, cmd_rs,
//                cmd_imm                 - command fields, latched on accept
//                done                    - one-cycle pulse after final write
//                writenum, write, data_in- register-file write port
//                readnum, data_out       - register-file read port
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_rd,
    input  logic [2:0]  cmd_rs,
    input  logic [15:0] cmd_imm,
    output logic        done,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [2:0]  readnum,
    output logic [15:0] data_in,
    input  logic [15:0] data_out
);

    localparam logic [1:0] C_OP_LOAD  = 2'b00;
    localparam logic [1:0] C_OP_MOV   = 2'b01;
    localparam logic [1:0] C_OP_SWAP  = 2'b10;
    localparam logic [2:0] C_CNT_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MOV   = 3'd2,
        S_SWAP1 = 3'd3,
        S_SWAP2 = 3'd4,
        S_SWAP3 = 3'd5,
        S_CLR   = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_rd;
    logic [2:0]  r_rs;
    logic [15:0] r_imm;
    logic [15:0] r_temp;
    logic [2:0]  r_count;
    logic        w_accept;

    assign w_accept = cmd_valid & cmd_ready;

    // The operation itself is held by the state register from the accept
    // edge onward, so only the operand fields need latching here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rd    <= 3'd0;
            r_rs    <= 3'd0;
            r_imm   <= 16'd0;
            r_temp  <= 16'd0;
            r_count <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rd    <= cmd_rd;
                r_rs    <= cmd_rs;
                r_imm   <= cmd_imm;
                r_count <= 3'd0;
            end
            // Old R[rd] is parked here before SWAP2 overwrites it.
            if (r_state == S_SWAP1) begin
                r_temp <= data_out;
            end
            if (r_state == S_CLR) begin
                r_count <= r_count + 3'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        write     = 1'b0;
        writenum  = 3'd0;
        readnum   = 3'd0;
        data_in   = 16'd0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        C_OP_LOAD: w_next = S_LOAD;
                        C_OP_MOV:  w_next = S_MOV;
                        C_OP_SWAP: w_next = S_SWAP1;
                        default:   w_next = S_CLR;
                    endcase
                end
            end
            S_LOAD: begin
                write    = 1'b1;
                writenum = r_rd;
                data_in  = r_imm;
                w_next   = S_DONE;
            end
            S_MOV: begin
                // Read and write in the same cycle: data_out passes straight
                // through to data_in. rd==rs rewrites the same value.
                readnum  = r_rs;
                write    = 1'b1;
                writenum = r_rd;
                data_in  = data_out;
                w_next   = S_DONE;
            end
            S_SWAP1: begin
                readnum = r_rd;
                w_next  = S_SWAP2;
            end
            S_SWAP2: begin
                readnum  = r_rs;
                write    = 1'b1;
                writenum = r_rd;
                data_in  = data_out;
                w_next   = S_SWAP3;
            end
            S_SWAP3: begin
                write    = 1'b1;
                writenum = r_rs;
                data_in  = r_temp;
                w_next   = S_DONE;
            end
            S_CLR: begin
                write    = 1'b1;
                writenum = r_count;
                if (r_count == C_CNT_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sequencer
//  Description : Self-checking bench for regfile_sequencer. Hosts a
//                behavioural 8 x 16 register file on the DUT's ports and
//                compares write traffic, handshake timing and register
//                contents against a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs;
    logic [15:0] cmd_imm;
    logic        done;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic [15:0] data_in;
    logic [15:0] data_out;

    logic [15:0] rf  [8];   // register file driven by the DUT
    logic [15:0] mdl [8];   // reference contents

    int total;
    int bad;

    regfile_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_imm   (cmd_imm),
        .done      (done),
        .writenum  (writenum),
        .write     (write),
        .readnum   (readnum),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign data_out = rf[readnum];

    always @(posedge clk) begin
        if (write) rf[writenum] <= data_in;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), rf[i], mdl[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},    cmd_ready, 1);
        check({tag, "_done"},     done,      0);
        check({tag, "_write"},    write,     0);
        check({tag, "_writenum"}, writenum,  0);
        check({tag, "_readnum"},  readnum,   0);
        check({tag, "_data_in"},  data_in,   0);
    endtask

    // Issues one command starting at a negedge with the block idle, then
    // checks every following cycle up to and including the next IDLE cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [15:0] imm, input bit hold);
        logic [2:0]  ea [8];
        logic [15:0] ed [8];
        int          ne;
        int          edone;
        int          wi;
        bit          wexp;
        logic [15:0] t;

        // Expected write traffic, derived from the command's meaning.
        ne = 0;
        case (op)
            2'b00: begin ea[0] = rd; ed[0] = imm;     ne = 1; edone = 2; end
            2'b01: begin ea[0] = rd; ed[0] = mdl[rs]; ne = 1; edone = 2; end
            2'b10: begin
                ea[0] = rd; ed[0] = mdl[rs];
                ea[1] = rs; ed[1] = mdl[rd];
                ne = 2; edone = 4;
            end
            default: begin
                for (int i = 0; i < 8; i++) begin ea[i] = 3'(i); ed[i] = 16'h0; end
                ne = 8; edone = 9;
            end
        endcase

        check("ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;

        wi = 0;
        for (int n = 1; n <= edone + 1; n++) begin
            @(negedge clk);
            case (op)
                2'b00, 2'b01: wexp = (n == 1);
                2'b10:        wexp = (n == 2) || (n == 3);
                default:      wexp = (n >= 1) && (n <= 8);
            endcase
            check("write", write, wexp);
            check("done", done, n == edone);
            check("ready", cmd_ready, n == edone + 1);
            if (write && wexp && wi < ne) begin
                check("writenum", writenum, ea[wi]);
                check("data_in", data_in, ed[wi]);
                wi++;
            end
            if (hold && n < edone) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_rd    = 3'($urandom);
                cmd_rs    = 3'($urandom);
                cmd_imm   = 16'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        check("write_count", wi, ne);

        case (op)
            2'b00: mdl[rd] = imm;
            2'b01: mdl[rd] = mdl[rs];
            2'b10: begin t = mdl[rd]; mdl[rd] = mdl[rs]; mdl[rs] = t; end
            default: for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
        endcase
        check_regs();
    endtask

    task automatic preload_nonzero();
        for (int i = 0; i < 8; i++) run_cmd(2'b00, 3'(i), 3'd0, 16'($urandom) | 16'h0001, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rd    = 3'd0;
        cmd_rs    = 3'd0;
        cmd_imm   = 16'h0;
        for (int i = 0; i < 8; i++) begin rf[i] = 16'h0; mdl[i] = 16'h0; end

        #2;
        check_idle_outputs("in_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("after_reset");

        // Directed scenarios.
        run_cmd(2'b00, 3'd3, 3'd0, 16'h9122, 1'b0);
        run_cmd(2'b00, 3'd1, 3'd0, 16'h0027, 1'b0);
        run_cmd(2'b01, 3'd5, 3'd1, 16'h0000, 1'b0);
        check("mov_r5", rf[5], 16'h0027);
        run_cmd(2'b01, 3'd5, 3'd5, 16'h0000, 1'b0);
        check("mov_self_r5", rf[5], 16'h0027);
        run_cmd(2'b00, 3'd2, 3'd0, 16'h01E3, 1'b0);
        run_cmd(2'b00, 3'd6, 3'd0, 16'h0038, 1'b0);
        run_cmd(2'b10, 3'd2, 3'd6, 16'h0000, 1'b0);
        check("swap_r2", rf[2], 16'h0038);
        check("swap_r6", rf[6], 16'h01E3);
        run_cmd(2'b10, 3'd4, 3'd4, 16'h0000, 1'b0);
        run_cmd(2'b10, 3'd6, 3'd3, 16'h0000, 1'b1);
        preload_nonzero();
        run_cmd(2'b11, 3'd0, 3'd0, 16'h0000, 1'b0);

        // Randomized commands, some with cmd_valid held busy.
        for (int k = 0; k < 40; k++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom),
                    16'($urandom), 1'($urandom));
        end

        // Reset mid-CLEAR while the counter is at 3.
        preload_nonzero();
        check("ready_pre_clr", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_count3", writenum, 3);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("abort_done", done, 0);
            check("abort_write", write, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) mdl[i] = 16'h0;
        check_regs();
        check_idle_outputs("post_abort");
        @(negedge clk);
        check("post_abort_done", done, 0);
        run_cmd(2'b00, 3'd7, 3'd0, 16'hBEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven initiator for the 8 x 16-bit register file: it accepts register-level commands (load immediate, move, swap, clear-all) over a valid/ready handshake and drives the register file's write port (`writenum`, `write`, `data_in`) and read port (`readnum`, with `data_out` returned). It sits between the lab controller/testbench stimulus and the register file, on the initiator side of the register-file interface. Multi-cycle operations are sequenced by an internal FSM using the register file's single read port and single write port.

## Interface
- No parameters. Data width is fixed at 16 and register count at 8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces all state to reset values immediately.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the block accepts a command this cycle; high only in IDLE.
- `cmd_op` input 2: operation. 00 = LOAD, 01 = MOV, 10 = SWAP, 11 = CLEAR.
- `cmd_rd` input 3: destination register.
- `cmd_rs` input 3: source register (MOV, SWAP).
- `cmd_imm` input 16: immediate value (LOAD).
- `done` output 1: one-cycle pulse after the final write of a command.
- `writenum` output 3: register-file write address.
- `write` output 1: register-file write enable. The register file writes `data_in` into `writenum` on the rising edge when this is high.
- `readnum` output 3: register-file read address.
- `data_in` output 16: register-file write data.
- `data_out` input 16: register-file read data, combinational from `readnum`.

## Operation
- Accept: on a rising edge with `cmd_valid & cmd_ready`, latch `cmd_op`, `cmd_rd`, `cmd_rs`, and `cmd_imm` into internal registers and leave IDLE. Later changes on the `cmd_*` inputs are ignored until the block returns to IDLE.
- FSM states: IDLE, LOAD, MOV, SWAP1, SWAP2, SWAP3, CLR, DONE.
- LOAD (1 cycle): `write`=1, `writenum`=rd, `data_in`=imm. Next state is DONE.
- MOV (1 cycle): `readnum`=rs, `write`=1, `writenum`=rd, `data_in`=`data_out` (combinational pass-through). Next state is DONE.
- SWAP1: `readnum`=rd, `write`=0; the temp register captures `data_out` (old R[rd]).
- SWAP2: `readnum`=rs, `write`=1, `writenum`=rd, `data_in`=`data_out`.
- SWAP3: `write`=1, `writenum`=rs, `data_in`=temp. Next state is DONE.
- CLR: a 3-bit counter runs 0..7. Each cycle `write`=1, `writenum`=count, `data_in`=0. After count 7 the next state is DONE; the counter resets to 0 on entry.
- DONE: `done`=1 and `write`=0. Next state is IDLE.
- Outside the states listed above, register-file outputs are idle: `write`=0, and `writenum`, `readnum`, `data_in` are all 0.
- Degenerate cases:
  - MOV with rd==rs leaves R[rd] unchanged.
  - SWAP with rd==rs leaves R[rd] unchanged and still takes 3 cycles.
- `cmd_valid` while busy has no effect and creates no queueing.

## Timing
- Reset values: state=IDLE, temp=0, counter=0. Outputs during and after reset: `cmd_ready`=1, `done`=0, `write`=0, `writenum`=0, `readnum`=0, `data_in`=0.
- All outputs are decoded from registered state and latched fields, except `data_in` in MOV/SWAP2, which combinationally follows `data_out`.
- Latency, counted from the accept edge E to the cycle in which `done` is high:
  - LOAD: write lands at E+1, `done` during cycle E+1..E+2, `cmd_ready` again after E+2.
  - MOV: same as LOAD.
  - SWAP: writes land at E+2 and E+3, `done` after E+3, IDLE after E+4.
  - CLEAR: writes land at E+1 through E+8, `done` after E+8, IDLE after E+9.
- Back-to-back commands: the earliest next accept is the edge ending the IDLE cycle that follows DONE. Throughput is one LOAD per 3 cycles.
- Reset asserted mid-command: abort immediately to IDLE. Writes already clocked in stay in the register file, no further writes occur, and `done` is not pulsed.

## Test plan
- LOAD R3=16'h9122 -> exactly one cycle with `write`=1 and `writenum`=3; `done` pulses once; read R3 returns 16'h9122; `cmd_ready` is back 3 cycles after accept.
- LOAD R1=16'h0027, then MOV R5<-R1 -> R5 reads 16'h0027 and R1 is unchanged; MOV R5<-R5 leaves R5=16'h0027.
- LOAD R2=16'h01E3 and R6=16'h0038, then SWAP rd=2 rs=6 -> R2=16'h0038, R6=16'h01E3; `write` is high for exactly 2 cycles; `done` appears 4 cycles after accept.
- Load all eight registers with nonzero values, then CLEAR -> eight consecutive write cycles with `writenum` 0..7 and `data_in`=0; every register reads 0; `done` appears 9 cycles after accept.
- Hold `cmd_valid`=1 with changing fields during a SWAP -> `cmd_ready`=0 throughout, and the SWAP result uses only the fields latched at accept.
- Assert `reset` asynchronously during CLR at count 3 -> R0..R2 are 0, R3..R7 keep their prior values (R3 was not clocked), `done` never pulses, all outputs are at reset values, and `cmd_ready`=1.
